intersection_sequencer: RTL and testbench
=========================================

// Module: intersection_sequencer
// PURPOSE
//  Two-road (main/side) intersection controller with emergency-vehicle preemption.
//  Sequences the shared phase timer (drives ST, consumes TS/TL) and drives both light heads.
//  Sits between the sensor/emergency inputs and the timer + light outputs; the timer is external.
// PARAMETERS
//  SIDE_MAX_EXT  2  max extra TL periods side green may extend while SideCar stays high
//  EM_TIE_MAIN   1  1: main wins simultaneous new EmMain/EmSide; 0: side wins
// PORTS
//  Clk        in   1  system clock, all logic on posedge
//  Rst        in   1  synchronous, active-high reset
//  SideCar    in   1  vehicle waiting on side road (level)
//  EmMain     in   1  emergency request, main road (level, held until vehicle passes)
//  EmSide     in   1  emergency request, side road (level)
//  TS         in   1  timer short-elapsed flag
//  TL         in   1  timer long-elapsed flag
//  ST         out  1  timer restart, registered
//  MainLight  out  3  {R,Y,G} one-hot: 100 red, 010 yellow, 001 green
//  SideLight  out  3  same encoding
//  EmGrant    out  2  [1]=side, [0]=main emergency green active; at most one bit set
//  StateDbg   out  4  current state code
// BEHAVIOUR
//  Reset: state AR_SM, Main=Side=100, EmGrant=00, ST=1 every cycle Rst=1, ext count=0.
//  ST: high exactly one cycle, the first cycle of every state entry and of each side-green
//   extension; TS/TL ignored while ST=1 (stale). Timer is 0 the cycle after ST.
//  Dwell (condition already true): TS-exit state = 4 cycles, TL-exit state = 6 cycles.
//  Outputs are a function of the registered state only (Moore).
//  States / transitions (checked only when ST=0; emergency checks take priority):
//   MG    main 001, side 100. EmMain -> EG_M. EmSide -> MY. TL && SideCar -> MY.
//         No SideCar: hold indefinitely.
//   MY    main 010. TS -> EM_AR if EmMain|EmSide, else AR_MS.
//   AR_MS all red. TS -> EG_x if any Em (arbitrated), else SG (ext count cleared).
//   SG    side 001. EmSide -> EG_S. EmMain -> SY. TL && !SideCar -> SY.
//         TL && SideCar && ext<SIDE_MAX_EXT -> stay, pulse ST, ext++. TL && ext==MAX -> SY.
//   SY    side 010. TS -> EM_AR if any Em, else AR_SM.
//   AR_SM all red. TS -> EG_x if any Em, else MG.
//   EM_AR all red. TS -> EG_M/EG_S per winner.
//   EG_M  main 001, EmGrant=01. Hold while EmMain; !EmMain && TS -> EM_EXIT.
//   EG_S  side 001, EmGrant=10. Symmetric on EmSide.
//   EM_EXIT all red. TS -> EG of other road if its request high, else MG.
//  Arbitration: winner latched when EM_AR/AR_* is left; both high -> EM_TIE_MAIN.
//   Grant holder is never preempted by the other request; other served via EM_EXIT.
//  Request dropped before its EG entered: EM_AR/AR exit with no Em -> MG.
//  Never: green/yellow on both roads; green following green of other road without all-red.
//  Rst mid-operation: next cycle as reset values, regardless of state or pending requests.
//  ext counter 2 bits wide min, saturates at SIDE_MAX_EXT.
// STRUCTURE
//  Shared package traffic_pkg: state codes (4-bit localparams), light encodings
//   LIGHT_RED/YEL/GRN, EmGrant bit indices.
//  One natural sub-module: em_arbiter (request tie-break + winner latch).
//  Timer instantiated alongside in the intersection top level, not inside this block.
// TESTING (bench pairs the block with the timer, TIME_SMALL=2, TIME_LONG=4)
//  Reset 3 cycles, SideCar=0 -> AR_SM 4 cycles (Main=100), then MG held 50 cycles, ST=0.
//  SideCar=1 steady -> MG 6, MY 4, AR_MS 4, SG 6+6+6 (2 ext, ST pulses), SY 4, AR_SM 4.
//  In SG assert EmMain -> SY 4, EM_AR 4, EG_M (EmGrant=01) until EmMain drops, +TS, EM_EXIT 4, MG.
//  EmMain and EmSide rise same cycle in MY, EM_TIE_MAIN=1 -> EG_M, then EM_EXIT, EG_S.
//  In MG assert EmMain -> EG_M next cycle with ST=1, MainLight stays 001 throughout.
//  Rst pulse in EG_S -> next cycle AR_SM, both 100, EmGrant=00, ST=1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: state codes, light-head patterns,
// emergency-grant bit positions and the state -> light-head decode.
package traffic_pkg;

    localparam logic [3:0] SC_AR_SM   = 4'd0;
    localparam logic [3:0] SC_MG      = 4'd1;
    localparam logic [3:0] SC_MY      = 4'd2;
    localparam logic [3:0] SC_AR_MS   = 4'd3;
    localparam logic [3:0] SC_SG      = 4'd4;
    localparam logic [3:0] SC_SY      = 4'd5;
    localparam logic [3:0] SC_EM_AR   = 4'd6;
    localparam logic [3:0] SC_EG_M    = 4'd7;
    localparam logic [3:0] SC_EG_S    = 4'd8;
    localparam logic [3:0] SC_EM_EXIT = 4'd9;

    typedef enum logic [3:0] {
        AR_SM   = SC_AR_SM,
        MG      = SC_MG,
        MY      = SC_MY,
        AR_MS   = SC_AR_MS,
        SG      = SC_SG,
        SY      = SC_SY,
        EM_AR   = SC_EM_AR,
        EG_M    = SC_EG_M,
        EG_S    = SC_EG_S,
        EM_EXIT = SC_EM_EXIT
    } state_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int EMG_MAIN = 0;
    localparam int EMG_SIDE = 1;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic [1:0] grant;
    } heads_t;

    function automatic heads_t state_heads(input state_t s);
        heads_t h;
        h.main  = LIGHT_RED;
        h.side  = LIGHT_RED;
        h.grant = '0;
        case (s)
            MG:      h.main = LIGHT_GRN;
            MY:      h.main = LIGHT_YEL;
            SG:      h.side = LIGHT_GRN;
            SY:      h.side = LIGHT_YEL;
            EG_M: begin
                h.main           = LIGHT_GRN;
                h.grant[EMG_MAIN] = 1'b1;
            end
            EG_S: begin
                h.side           = LIGHT_GRN;
                h.grant[EMG_SIDE] = 1'b1;
            end
            default: ;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/em_arbiter.sv
// Emergency request tie-break plus a record of which road was last granted, so the
// exit state knows which road counts as "the other one".
module em_arbiter #(
    parameter bit EM_TIE_MAIN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic em_main_i,
    input  logic em_side_i,
    input  logic latch_i,
    input  logic latch_main_i,
    output logic any_o,
    output logic win_main_o,
    output logic served_main_o
);

    logic served_main_q;

    assign any_o         = em_main_i | em_side_i;
    assign win_main_o    = em_main_i && (!em_side_i || EM_TIE_MAIN);
    assign served_main_o = served_main_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            served_main_q <= 1'b0;
        end else if (latch_i) begin
            served_main_q <= latch_main_i;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Main/side intersection sequencer with emergency preemption. Drives the external phase
// timer restart (ST) and consumes its short/long elapsed flags; light heads are Moore.
module intersection_sequencer
    import traffic_pkg::*;
#(
    parameter int SIDE_MAX_EXT = 2,
    parameter int EM_TIE_MAIN  = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SideCar,
    input  logic       EmMain,
    input  logic       EmSide,
    input  logic       TS,
    input  logic       TL,
    output logic       ST,
    output logic [2:0] MainLight,
    output logic [2:0] SideLight,
    output logic [1:0] EmGrant,
    output logic [3:0] StateDbg
);

    localparam int EXT_W = (SIDE_MAX_EXT < 4) ? 2 : $clog2(SIDE_MAX_EXT + 1);
    localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(SIDE_MAX_EXT);

    state_t           state_q, state_d;
    logic             st_q, st_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic             em_any, win_main, served_main;
    logic             arb_latch;
    heads_t           heads;

    em_arbiter #(.EM_TIE_MAIN(EM_TIE_MAIN != 0)) u_arb (
        .clk_i         (Clk),
        .rst_i         (Rst),
        .em_main_i     (EmMain),
        .em_side_i     (EmSide),
        .latch_i       (arb_latch),
        .latch_main_i  (state_d == EG_M),
        .any_o         (em_any),
        .win_main_o    (win_main),
        .served_main_o (served_main)
    );

    // Timer flags are stale during the restart cycle, so nothing is evaluated while st_q is set.
    always_comb begin
        state_d = state_q;
        st_d    = 1'b0;
        ext_d   = ext_q;
        if (!st_q) begin
            unique case (state_q)
                MG: begin
                    if (EmMain)                state_d = EG_M;
                    else if (EmSide)           state_d = MY;
                    else if (TL && SideCar)    state_d = MY;
                end
                MY: if (TS) state_d = em_any ? EM_AR : AR_MS;
                AR_MS: begin
                    if (TS) begin
                        if (em_any) begin
                            state_d = win_main ? EG_M : EG_S;
                        end else begin
                            state_d = SG;
                            ext_d   = '0;
                        end
                    end
                end
                SG: begin
                    if (EmSide)      state_d = EG_S;
                    else if (EmMain) state_d = SY;
                    else if (TL) begin
                        if (SideCar && ext_q < EXT_MAX) begin
                            st_d  = 1'b1;
                            ext_d = ext_q + EXT_W'(1);
                        end else begin
                            state_d = SY;
                        end
                    end
                end
                SY: if (TS) state_d = em_any ? EM_AR : AR_SM;
                AR_SM, EM_AR: begin
                    if (TS) state_d = em_any ? (win_main ? EG_M : EG_S) : MG;
                end
                EG_M: if (!EmMain && TS) state_d = EM_EXIT;
                EG_S: if (!EmSide && TS) state_d = EM_EXIT;
                EM_EXIT: begin
                    if (TS) begin
                        if (served_main && EmSide)       state_d = EG_S;
                        else if (!served_main && EmMain) state_d = EG_M;
                        else                             state_d = MG;
                    end
                end
                default: state_d = AR_SM;
            endcase
        end
        if (state_d != state_q) st_d = 1'b1;
    end

    assign arb_latch = (state_d != state_q) && (state_d == EG_M || state_d == EG_S);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= AR_SM;
            st_q    <= 1'b1;
            ext_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            ext_q   <= ext_d;
        end
    end

    assign heads     = state_heads(state_q);
    assign MainLight = heads.main;
    assign SideLight = heads.side;
    assign EmGrant   = heads.grant;
    assign ST        = st_q;
    assign StateDbg  = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed phase-table bench: sequencer paired with a small short/long phase timer.
module tb_intersection_sequencer;
    import traffic_pkg::*;

    localparam int TIME_SMALL = 2;
    localparam int TIME_LONG  = 4;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic       Clk, Rst, SideCar, EmMain, EmSide, TS, TL, ST;
    logic [2:0] MainLight, SideLight;
    logic [1:0] EmGrant;
    logic [3:0] StateDbg;

    int checks = 0;
    int fails  = 0;
    int tcnt   = 0;

    intersection_sequencer #(.SIDE_MAX_EXT(2), .EM_TIE_MAIN(1)) dut (
        .Clk(Clk), .Rst(Rst), .SideCar(SideCar), .EmMain(EmMain), .EmSide(EmSide),
        .TS(TS), .TL(TL), .ST(ST), .MainLight(MainLight), .SideLight(SideLight),
        .EmGrant(EmGrant), .StateDbg(StateDbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ST === 1'b1) tcnt <= 0;
        else if (tcnt < 15) tcnt <= tcnt + 1;
    end
    assign TS = (tcnt >= TIME_SMALL);
    assign TL = (tcnt >= TIME_LONG);

    typedef struct {
        logic       rst, sc, em_m, em_s;
        int         dur;
        logic [3:0] st8;
        logic [2:0] ml, sl;
        logic [1:0] eg;
        logic       st0, stn;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    task automatic add(input logic rst, input logic sc, input logic em_m, input logic em_s,
                       input int dur, input logic [3:0] st8, input logic [2:0] ml,
                       input logic [2:0] sl, input logic [1:0] eg, input logic st0,
                       input logic stn = 1'b0);
        vec_t r;
        r.rst = rst; r.sc = sc; r.em_m = em_m; r.em_s = em_s; r.dur = dur;
        r.st8 = st8; r.ml = ml; r.sl = sl; r.eg = eg; r.st0 = st0; r.stn = stn;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [3:0] es, input logic [2:0] em,
                       input logic [2:0] esl, input logic [1:0] eg, input logic est);
        checks++;
        if (StateDbg !== es || MainLight !== em || SideLight !== esl || EmGrant !== eg || ST !== est) begin
            fails++;
            $display("FAIL %s: got state=%0d main=%b side=%b emg=%b st=%b, want state=%0d main=%b side=%b emg=%b st=%b",
                     nm, StateDbg, MainLight, SideLight, EmGrant, ST, es, em, esl, eg, est);
        end
    endtask

    initial begin
        // rst sc emM emS dur state ML SL EG st0 [stn]
        add(1,0,0,0, 3, SC_AR_SM,   LR,LR,2'b00,1,1);
        add(0,0,0,0, 4, SC_AR_SM,   LR,LR,2'b00,1);
        add(0,0,0,0,50, SC_MG,      LG,LR,2'b00,1);
        add(0,1,0,0, 1, SC_MG,      LG,LR,2'b00,0);
        add(0,1,0,0, 4, SC_MY,      LY,LR,2'b00,1);
        add(0,1,0,0, 4, SC_AR_MS,   LR,LR,2'b00,1);
        add(0,1,0,0, 6, SC_SG,      LR,LG,2'b00,1);
        add(0,1,0,0, 6, SC_SG,      LR,LG,2'b00,1);
        add(0,1,0,0, 6, SC_SG,      LR,LG,2'b00,1);
        add(0,1,0,0, 4, SC_SY,      LR,LY,2'b00,1);
        add(0,1,0,0, 4, SC_AR_SM,   LR,LR,2'b00,1);
        add(0,1,0,0, 6, SC_MG,      LG,LR,2'b00,1);
        add(0,1,0,0, 4, SC_MY,      LY,LR,2'b00,1);
        add(0,1,0,0, 4, SC_AR_MS,   LR,LR,2'b00,1);
        add(0,1,0,0, 2, SC_SG,      LR,LG,2'b00,1);
        add(0,1,1,0, 1, SC_SG,      LR,LG,2'b00,0);
        add(0,1,1,0, 4, SC_SY,      LR,LY,2'b00,1);
        add(0,1,1,0, 4, SC_EM_AR,   LR,LR,2'b00,1);
        add(0,1,1,0, 8, SC_EG_M,    LG,LR,2'b01,1);
        add(0,0,0,0, 1, SC_EG_M,    LG,LR,2'b01,0);
        add(0,0,0,0, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,0,0,0, 3, SC_MG,      LG,LR,2'b00,1);
        add(0,0,1,0, 1, SC_MG,      LG,LR,2'b00,0);
        add(0,0,1,0, 2, SC_EG_M,    LG,LR,2'b01,1);
        add(0,0,0,0, 2, SC_EG_M,    LG,LR,2'b01,0);
        add(0,0,0,0, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,1,0,0, 6, SC_MG,      LG,LR,2'b00,1);
        add(0,1,0,0, 1, SC_MY,      LY,LR,2'b00,1);
        add(0,1,1,1, 3, SC_MY,      LY,LR,2'b00,0);
        add(0,1,1,1, 4, SC_EM_AR,   LR,LR,2'b00,1);
        add(0,1,1,1, 6, SC_EG_M,    LG,LR,2'b01,1);
        add(0,1,0,1, 1, SC_EG_M,    LG,LR,2'b01,0);
        add(0,1,0,1, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,1,0,1, 3, SC_EG_S,    LR,LG,2'b10,1);
        add(1,1,0,1, 1, SC_EG_S,    LR,LG,2'b10,0);
        add(0,0,0,1, 4, SC_AR_SM,   LR,LR,2'b00,1);
        add(0,0,0,1, 2, SC_EG_S,    LR,LG,2'b10,1);
        add(0,0,0,0, 2, SC_EG_S,    LR,LG,2'b10,0);
        add(0,0,0,0, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,0,0,0, 3, SC_MG,      LG,LR,2'b00,1);
        add(0,0,0,1, 1, SC_MG,      LG,LR,2'b00,0);
        add(0,0,0,1, 4, SC_MY,      LY,LR,2'b00,1);
        add(0,0,0,1, 1, SC_EM_AR,   LR,LR,2'b00,1);
        add(0,0,0,0, 3, SC_EM_AR,   LR,LR,2'b00,0);
        add(0,1,0,0, 6, SC_MG,      LG,LR,2'b00,1);
        add(0,1,0,0, 4, SC_MY,      LY,LR,2'b00,1);
        add(0,1,0,0, 4, SC_AR_MS,   LR,LR,2'b00,1);
        add(0,1,0,0, 2, SC_SG,      LR,LG,2'b00,1);
        add(0,1,0,1, 1, SC_SG,      LR,LG,2'b00,0);
        add(0,1,0,1, 2, SC_EG_S,    LR,LG,2'b10,1);
        add(0,1,1,0, 2, SC_EG_S,    LR,LG,2'b10,0);
        add(0,1,1,0, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,1,1,0, 2, SC_EG_M,    LG,LR,2'b01,1);
        add(0,1,0,0, 2, SC_EG_M,    LG,LR,2'b01,0);
        add(0,1,0,0, 4, SC_EM_EXIT, LR,LR,2'b00,1);
        add(0,1,0,0, 6, SC_MG,      LG,LR,2'b00,1);
        add(0,1,0,0, 4, SC_MY,      LY,LR,2'b00,1);
        add(0,0,0,0, 4, SC_AR_MS,   LR,LR,2'b00,1);
        add(0,0,0,0, 6, SC_SG,      LR,LG,2'b00,1);
        add(0,0,0,0, 4, SC_SY,      LR,LY,2'b00,1);
        add(0,0,0,0, 4, SC_AR_SM,   LR,LR,2'b00,1);
        add(0,0,0,0, 3, SC_MG,      LG,LR,2'b00,1);

        Rst = 1'b1; SideCar = 1'b0; EmMain = 1'b0; EmSide = 1'b0;
        @(posedge Clk);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            for (int c = 0; c < v.dur; c++) begin
                @(negedge Clk);
                chk($sformatf("rec%0d.c%0d", i, c), v.st8, v.ml, v.sl, v.eg, (c == 0) ? v.st0 : v.stn);
                Rst = v.rst; SideCar = v.sc; EmMain = v.em_m; EmSide = v.em_s;
            end
        end

        // Two-cycle reset while MG holds with requests pending, then the pending EmMain is served.
        @(negedge Clk);
        chk("pre_rst_mg", SC_MG, LG, LR, 2'b00, 1'b0);
        Rst = 1'b1; EmMain = 1'b1; SideCar = 1'b1;
        @(negedge Clk);
        chk("rst_a", SC_AR_SM, LR, LR, 2'b00, 1'b1);
        @(negedge Clk);
        chk("rst_b", SC_AR_SM, LR, LR, 2'b00, 1'b1);
        Rst = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge Clk);
            chk($sformatf("post_rst.c%0d", c), SC_AR_SM, LR, LR, 2'b00, 1'b0);
        end
        @(negedge Clk);
        chk("post_rst_egm", SC_EG_M, LG, LR, 2'b01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
